// File: rtl/tawas_ls_pkg.sv
// Shared types and constants for the tawas_ls load/store pipeline.
package tawas_ls_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2,
    LS_RSVD = 2'd3
  } ls_size_e;

  // Read data appears on din this many cycles after dcs.
  localparam int LS_DIN_LATENCY = 2;
  // Issue (S0) through load writeback (S3).
  localparam int LS_STAGES = 4;

  // Per-load bookkeeping carried from issue until read data is captured.
  typedef struct packed {
    logic       vld;
    logic [2:0] sel;
    logic [1:0] lane;
    ls_size_e   size;
    logic       sgn;
  } ld_meta_t;

  function automatic logic ls_legal(ls_size_e size, logic [1:0] lane);
    case (size)
      LS_BYTE: ls_legal = 1'b1;
      LS_HALF: ls_legal = ~lane[0];
      LS_WORD: ls_legal = (lane == 2'b00);
      default: ls_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tawas_ls_align.sv
// Byte-lane steering: store replication and lane mask, load extraction and
// zero/sign extension. Purely combinational.
module tawas_ls_align
  import tawas_ls_pkg::*;
(
  input  ls_size_e    size_i,
  input  logic [1:0]  lane_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [15:0] rd_lane;

  // Bring the addressed lane down to bit 0; only the low half is ever needed.
  assign rd_lane = 16'(rdata_i >> {lane_i, 3'b000});

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    mask_o  = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      LS_BYTE: begin
        mask_o  = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & rd_lane[7]}}, rd_lane[7:0]};
      end
      LS_HALF: begin
        mask_o  = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & rd_lane[15]}}, rd_lane};
      end
      LS_WORD: mask_o = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/tawas_ls.sv
// Tawas load/store unit: S0 issue to the data bus, S1 pointer writeback,
// S2 read-data capture, S3 load writeback. One op per cycle, no stalls.
module tawas_ls
  import tawas_ls_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_op_vld_i,
  input  logic        ls_op_store_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_signed_i,
  input  logic [31:0] ls_offset_i,
  input  logic        ls_ptr_wb_i,
  input  logic [2:0]  ls_ptr_sel_i,
  input  logic [2:0]  ls_load_sel_i,
  input  logic [31:0] ls_ptr_i,
  input  logic [31:0] ls_store_i,
  output logic        ls_ptr_upd_vld_o,
  output logic [2:0]  ls_ptr_upd_sel_o,
  output logic [31:0] ls_ptr_upd_o,
  output logic        ls_load_vld_o,
  output logic [2:0]  ls_load_sel_o,
  output logic [31:0] ls_load_o,
  output logic        ls_err_o,
  output logic        dcs_o,
  output logic        dwr_o,
  output logic [31:0] daddr_o,
  output logic [3:0]  dmask_o,
  output logic [31:0] dout_o,
  input  logic [31:0] din_i
);

  logic [31:0] ea;
  ls_size_e    size;
  logic        issue;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [31:0] unused_st_rdata;

  logic        ptr_upd_vld_d, ptr_upd_vld_q;
  logic [2:0]  ptr_upd_sel_d, ptr_upd_sel_q;
  logic [31:0] ptr_upd_d, ptr_upd_q;
  logic        err_d, err_q;
  ld_meta_t    ld_meta_d;
  ld_meta_t    ld_pipe_q [LS_DIN_LATENCY];
  ld_meta_t    ld_last;
  logic [31:0] ld_ext;
  logic [3:0]  unused_ld_mask;
  logic [31:0] unused_ld_wdata;
  logic        load_vld_d, load_vld_q;
  logic [2:0]  load_sel_d, load_sel_q;
  logic [31:0] load_d, load_q;

  // S0: effective address wraps modulo 2^32 by construction.
  assign ea    = ls_ptr_i + ls_offset_i;
  assign size  = ls_size_e'(ls_size_i);
  assign issue = ls_op_vld_i & ls_legal(size, ea[1:0]);

  tawas_ls_align u_align_st (
    .size_i   (size),
    .lane_i   (ea[1:0]),
    .signed_i (1'b0),
    .wdata_i  (ls_store_i),
    .rdata_i  (32'h0),
    .mask_o   (st_mask),
    .wdata_o  (st_wdata),
    .rdata_o  (unused_st_rdata)
  );

  assign dcs_o   = issue;
  assign dwr_o   = issue & ls_op_store_i;
  assign daddr_o = issue ? {ea[31:2], 2'b00} : 32'h0;
  assign dmask_o = issue ? st_mask : 4'b0000;
  assign dout_o  = dwr_o ? st_wdata : 32'h0;

  assign ptr_upd_vld_d = issue & ls_ptr_wb_i;
  assign ptr_upd_sel_d = ptr_upd_vld_d ? ls_ptr_sel_i : 3'd0;
  assign ptr_upd_d     = ptr_upd_vld_d ? ea : 32'h0;
  assign err_d         = ls_op_vld_i & ~issue;

  always_comb begin
    ld_meta_d      = '0;
    ld_meta_d.vld  = issue & ~ls_op_store_i;
    ld_meta_d.sel  = ls_load_sel_i;
    ld_meta_d.lane = ea[1:0];
    ld_meta_d.size = size;
    ld_meta_d.sgn  = ls_signed_i;
  end

  // Oldest entry is in S2, the cycle its read data is on din.
  assign ld_last = ld_pipe_q[LS_DIN_LATENCY-1];

  tawas_ls_align u_align_ld (
    .size_i   (ld_last.size),
    .lane_i   (ld_last.lane),
    .signed_i (ld_last.sgn),
    .wdata_i  (32'h0),
    .rdata_i  (din_i),
    .mask_o   (unused_ld_mask),
    .wdata_o  (unused_ld_wdata),
    .rdata_o  (ld_ext)
  );

  assign load_vld_d = ld_last.vld;
  assign load_sel_d = ld_last.vld ? ld_last.sel : 3'd0;
  assign load_d     = ld_last.vld ? ld_ext : 32'h0;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of its neighbour; blocking would collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_upd_vld_q <= 1'b0;
      ptr_upd_sel_q <= 3'd0;
      ptr_upd_q     <= 32'h0;
      err_q         <= 1'b0;
      load_vld_q    <= 1'b0;
      load_sel_q    <= 3'd0;
      load_q        <= 32'h0;
      // NOTE: the pipe array is reset too: its valid bits must clear so
      // in-flight loads are dropped, not written back after reset.
      for (int i = 0; i < LS_DIN_LATENCY; i++) ld_pipe_q[i] <= '0;
    end else begin
      ptr_upd_vld_q <= ptr_upd_vld_d;
      ptr_upd_sel_q <= ptr_upd_sel_d;
      ptr_upd_q     <= ptr_upd_d;
      err_q         <= err_d;
      load_vld_q    <= load_vld_d;
      load_sel_q    <= load_sel_d;
      load_q        <= load_d;
      ld_pipe_q[0]  <= ld_meta_d;
      for (int i = 1; i < LS_DIN_LATENCY; i++) ld_pipe_q[i] <= ld_pipe_q[i-1];
    end
  end

  assign ls_ptr_upd_vld_o = ptr_upd_vld_q;
  assign ls_ptr_upd_sel_o = ptr_upd_sel_q;
  assign ls_ptr_upd_o     = ptr_upd_q;
  assign ls_err_o         = err_q;
  assign ls_load_vld_o    = load_vld_q;
  assign ls_load_sel_o    = load_sel_q;
  assign ls_load_o        = load_q;

endmodule

// File: tb/tb_tawas_ls.sv
// Randomized bench for tawas_ls against a per-cycle expectation model.
module tb_tawas_ls;
  import tawas_ls_pkg::*;

  localparam int N = 400;

  typedef struct {
    logic        vld;
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] off;
    logic        wb;
    logic [2:0]  psel;
    logic [2:0]  lsel;
    logic [31:0] ptr;
    logic [31:0] st;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_op_vld_i, ls_op_store_i, ls_signed_i, ls_ptr_wb_i;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_offset_i, ls_ptr_i, ls_store_i, din_i;
  logic [2:0]  ls_ptr_sel_i, ls_load_sel_i;
  logic        ls_ptr_upd_vld_o, ls_load_vld_o, ls_err_o, dcs_o, dwr_o;
  logic [2:0]  ls_ptr_upd_sel_o, ls_load_sel_o;
  logic [31:0] ls_ptr_upd_o, ls_load_o, daddr_o, dout_o;
  logic [3:0]  dmask_o;

  int n_checks = 0;
  int n_errors = 0;

  op_t         ops    [N];
  logic [31:0] din_at [N + 8];
  logic        exp_pv [N + 8];
  logic [2:0]  exp_ps [N + 8];
  logic [31:0] exp_pu [N + 8];
  logic        exp_er [N + 8];
  logic        exp_lv [N + 8];
  logic [2:0]  exp_ls [N + 8];
  logic [31:0] exp_ld [N + 8];

  tawas_ls dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ls_op_vld_i      (ls_op_vld_i),
    .ls_op_store_i    (ls_op_store_i),
    .ls_size_i        (ls_size_i),
    .ls_signed_i      (ls_signed_i),
    .ls_offset_i      (ls_offset_i),
    .ls_ptr_wb_i      (ls_ptr_wb_i),
    .ls_ptr_sel_i     (ls_ptr_sel_i),
    .ls_load_sel_i    (ls_load_sel_i),
    .ls_ptr_i         (ls_ptr_i),
    .ls_store_i       (ls_store_i),
    .ls_ptr_upd_vld_o (ls_ptr_upd_vld_o),
    .ls_ptr_upd_sel_o (ls_ptr_upd_sel_o),
    .ls_ptr_upd_o     (ls_ptr_upd_o),
    .ls_load_vld_o    (ls_load_vld_o),
    .ls_load_sel_o    (ls_load_sel_o),
    .ls_load_o        (ls_load_o),
    .ls_err_o         (ls_err_o),
    .dcs_o            (dcs_o),
    .dwr_o            (dwr_o),
    .daddr_o          (daddr_o),
    .dmask_o          (dmask_o),
    .dout_o           (dout_o),
    .din_i            (din_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference rules: an access covers nb = 2**size bytes starting at ea[1:0].
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic m_legal(input logic [1:0] size, input logic [31:0] ea);
    if (size == 2'd3) return 1'b0;
    return (ea % nbytes(size)) == 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [1:0] size, input logic [31:0] ea);
    logic [3:0] m = '0;
    for (int k = 0; k < 4; k++)
      m[k] = (k >= int'(ea[1:0])) && (k < int'(ea[1:0]) + nbytes(size));
    return m;
  endfunction

  function automatic logic [31:0] m_dout(input logic [1:0] size, input logic [31:0] st);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = st[8*(k % nbytes(size)) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] ea, input logic [31:0] din);
    logic [63:0] v, keep;
    int bits;
    bits = 8 * nbytes(size);
    v    = 64'(din) >> (8 * int'(ea[1:0]));
    keep = (64'd1 << bits) - 64'd1;
    v    = v & keep;
    if (bits < 32 && sgn && ((v >> (bits - 1)) & 64'd1) == 64'd1) v = v | ~keep;
    return v[31:0];
  endfunction

  function automatic op_t mk(input logic store, input logic [1:0] size, input logic sgn,
                             input logic [31:0] ptr, input logic [31:0] off, input logic wb,
                             input logic [2:0] psel, input logic [2:0] lsel,
                             input logic [31:0] st);
    op_t o;
    o.vld = 1'b1; o.store = store; o.size = size; o.sgn = sgn; o.ptr = ptr;
    o.off = off; o.wb = wb; o.psel = psel; o.lsel = lsel; o.st = st;
    return o;
  endfunction

  task automatic drive(input op_t o, input logic [31:0] din);
    ls_op_vld_i   = o.vld;
    ls_op_store_i = o.store;
    ls_size_i     = o.size;
    ls_signed_i   = o.sgn;
    ls_offset_i   = o.off;
    ls_ptr_wb_i   = o.wb;
    ls_ptr_sel_i  = o.psel;
    ls_load_sel_i = o.lsel;
    ls_ptr_i      = o.ptr;
    ls_store_i    = o.st;
    din_i         = din;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ptr_vld"}, 32'(ls_ptr_upd_vld_o), 32'h0);
    check({tag, "_ptr_sel"}, 32'(ls_ptr_upd_sel_o), 32'h0);
    check({tag, "_ptr_upd"}, ls_ptr_upd_o, 32'h0);
    check({tag, "_ld_vld"}, 32'(ls_load_vld_o), 32'h0);
    check({tag, "_ld_sel"}, 32'(ls_load_sel_o), 32'h0);
    check({tag, "_ld"}, ls_load_o, 32'h0);
    check({tag, "_err"}, 32'(ls_err_o), 32'h0);
    check({tag, "_dcs"}, 32'(dcs_o), 32'h0);
    check({tag, "_dwr"}, 32'(dwr_o), 32'h0);
    check({tag, "_daddr"}, daddr_o, 32'h0);
    check({tag, "_dmask"}, 32'(dmask_o), 32'h0);
    check({tag, "_dout"}, dout_o, 32'h0);
  endtask

  initial begin
    op_t idle;
    idle = '{default: '0};

    for (int i = 0; i < N + 8; i++) begin
      din_at[i] = $urandom;
      exp_pv[i] = 1'b0; exp_ps[i] = '0; exp_pu[i] = '0; exp_er[i] = 1'b0;
      exp_lv[i] = 1'b0; exp_ls[i] = '0; exp_ld[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      ops[i].vld   = ($urandom_range(0, 9) != 0);
      ops[i].store = ($urandom_range(0, 2) == 0);
      ops[i].size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      ops[i].sgn   = 1'($urandom);
      ops[i].wb    = 1'($urandom);
      ops[i].psel  = 3'($urandom);
      ops[i].lsel  = 3'($urandom);
      ops[i].ptr   = $urandom;
      if ($urandom_range(0, 1) == 0) ops[i].ptr[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) ops[i].ptr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      ops[i].off   = 32'($urandom_range(0, 15));
      ops[i].st    = $urandom;
    end

    ops[0] = mk(1'b0, 2'd2, 1'b0, 32'h1000, 32'd8, 1'b0, 3'd1, 3'd3, 32'h0);
    din_at[2] = 32'hDEAD_BEEF;
    ops[1] = mk(1'b0, 2'd0, 1'b1, 32'h2000, 32'd3, 1'b0, 3'd0, 3'd4, 32'h0);
    din_at[3] = 32'h8000_0000;
    ops[2] = mk(1'b0, 2'd0, 1'b0, 32'h2000, 32'd3, 1'b0, 3'd0, 3'd5, 32'h0);
    din_at[4] = 32'h8000_0000;
    ops[3] = mk(1'b1, 2'd1, 1'b0, 32'h10, 32'd2, 1'b1, 3'd6, 3'd0, 32'h1234_ABCD);
    ops[4] = mk(1'b0, 2'd2, 1'b0, 32'h1000, 32'd2, 1'b1, 3'd2, 3'd2, 32'h0);
    ops[5] = mk(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'd8, 1'b1, 3'd5, 3'd6, 32'h0);
    ops[6] = mk(1'b0, 2'd1, 1'b1, 32'h4002, 32'd0, 1'b1, 3'd2, 3'd2, 32'h0);
    for (int i = N - 6; i < N - 2; i++)
      ops[i] = mk(1'b0, 2'd2, 1'b0, 32'h3000 + 32'(4 * i), 32'd4, 1'b0, 3'd0, 3'(i), 32'h0);
    ops[N-2] = idle;
    ops[N-1] = idle;

    rst_n = 1'b0;
    drive(idle, 32'h0);
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int c = 0; c < N; c++) begin
      logic [31:0] ea;
      logic        legal;
      @(posedge clk);
      #1 drive(ops[c], din_at[c]);
      ea    = ops[c].ptr + ops[c].off;
      legal = ops[c].vld && m_legal(ops[c].size, ea);
      if (ops[c].vld && !legal) exp_er[c+1] = 1'b1;
      if (legal && ops[c].wb) begin
        exp_pv[c+1] = 1'b1; exp_ps[c+1] = ops[c].psel; exp_pu[c+1] = ea;
      end
      if (legal && !ops[c].store) begin
        exp_lv[c+LS_STAGES-1] = 1'b1;
        exp_ls[c+LS_STAGES-1] = ops[c].lsel;
        exp_ld[c+LS_STAGES-1] = m_load(ops[c].size, ops[c].sgn, ea, din_at[c+LS_DIN_LATENCY]);
      end

      @(negedge clk);
      check($sformatf("dcs@%0d", c), 32'(dcs_o), 32'(legal));
      check($sformatf("dwr@%0d", c), 32'(dwr_o), 32'(legal & ops[c].store));
      if (legal) begin
        check($sformatf("daddr@%0d", c), daddr_o, {ea[31:2], 2'b00});
        check($sformatf("dmask@%0d", c), 32'(dmask_o), 32'(m_mask(ops[c].size, ea)));
        if (ops[c].store)
          check($sformatf("dout@%0d", c), dout_o, m_dout(ops[c].size, ops[c].st));
      end
      check($sformatf("ptr_vld@%0d", c), 32'(ls_ptr_upd_vld_o), 32'(exp_pv[c]));
      check($sformatf("ptr_sel@%0d", c), 32'(ls_ptr_upd_sel_o), 32'(exp_ps[c]));
      check($sformatf("ptr_upd@%0d", c), ls_ptr_upd_o, exp_pu[c]);
      check($sformatf("err@%0d", c), 32'(ls_err_o), 32'(exp_er[c]));
      check($sformatf("ld_vld@%0d", c), 32'(ls_load_vld_o), 32'(exp_lv[c]));
      check($sformatf("ld_sel@%0d", c), 32'(ls_load_sel_o), 32'(exp_ls[c]));
      check($sformatf("ld@%0d", c), ls_load_o, exp_ld[c]);

      // Worked examples, with their expected values written out literally.
      case (c)
        0: begin
          check("ex_word_daddr", daddr_o, 32'h0000_1008);
          check("ex_word_dmask", 32'(dmask_o), 32'hF);
        end
        1: check("ex_sbyte_dmask", 32'(dmask_o), 32'h8);
        3: begin
          check("ex_word_load", ls_load_o, 32'hDEAD_BEEF);
          check("ex_hst_dwr", 32'(dwr_o), 32'h1);
          check("ex_hst_dmask", 32'(dmask_o), 32'hC);
          check("ex_hst_dout", dout_o, 32'hABCD_ABCD);
        end
        4: begin
          check("ex_sbyte_load", ls_load_o, 32'hFFFF_FF80);
          check("ex_hst_ptr_upd", ls_ptr_upd_o, 32'h0000_0012);
          check("ex_mis_dcs", 32'(dcs_o), 32'h0);
        end
        5: begin
          check("ex_ubyte_load", ls_load_o, 32'h0000_0080);
          check("ex_mis_err", 32'(ls_err_o), 32'h1);
          check("ex_mis_no_ptr", 32'(ls_ptr_upd_vld_o), 32'h0);
        end
        6: check("ex_wrap_ptr_upd", ls_ptr_upd_o, 32'h0000_0004);
        7: check("ex_mis_no_load", 32'(ls_load_vld_o), 32'h0);
        default: ;
      endcase
    end

    // Last load is still in flight: reset must discard it.
    #2 rst_n = 1'b0;
    drive(idle, 32'h0);
    #1 check_all_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_all_zero($sformatf("postrst%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tawas_ls.md
TAWAS_LS -- requirements
Module: tawas_ls

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RST_N  in  1  asynchronous, active-low reset.
REQ-003 LS_OP_VLD  in  1  load/store operation issued this cycle (stage S0).
REQ-004 LS_OP_STORE  in  1  1=store, 0=load.
REQ-005 LS_SIZE  in  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-006 LS_SIGNED  in  1  sign-extend load data (byte/half only).
REQ-007 LS_OFFSET  in  32  pre-scaled byte offset from decode.
REQ-008 LS_PTR_WB  in  1  write effective address back to pointer register.
REQ-009 LS_PTR_SEL / LS_LOAD_SEL  in  3 each  pointer register index / load destination index.
REQ-010 LS_PTR, LS_STORE  in  32 each  pointer and store data read from the register file in S0.
REQ-011 LS_PTR_UPD_VLD, LS_PTR_UPD_SEL, LS_PTR_UPD  out  1/3/32  pointer writeback to register file.
REQ-012 LS_LOAD_VLD, LS_LOAD_SEL, LS_LOAD  out  1/3/32  load writeback to register file.
REQ-013 LS_ERR  out  1  one-cycle pulse: misaligned or reserved-size op.
REQ-014 DCS, DWR  out  1 each  data bus select / write strobe.
REQ-015 DADDR  out  32  byte address, bits [1:0] forced to 0.
REQ-016 DMASK  out  4  byte-lane enables, little-endian.
REQ-017 DOUT / DIN  out / in  32 each  write data / read data; DIN valid exactly 2 cycles after DCS.

Function
REQ-018 EA = LS_PTR + LS_OFFSET, modulo 2^32; wrap-around produces no error.
REQ-019 S0 (issue cycle): DCS, DWR, DADDR, DMASK, DOUT are combinational from S0 inputs; DCS = LS_OP_VLD and op legal.
REQ-020 Legal op: size 0 any EA; size 1 EA[0]=0; size 2 EA[1:0]=0; size 3 always illegal.
REQ-021 Illegal op: DCS=0, no pointer or load writeback, LS_ERR=1 in S1 only.
REQ-022 DMASK: byte 1<<EA[1:0]; half 4'b0011 or 4'b1100 by EA[1]; word 4'b1111.
REQ-023 DOUT: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-024 S1: LS_PTR_UPD_VLD=1 with LS_PTR_UPD=EA and registered LS_PTR_SEL iff S0 op legal and LS_PTR_WB; loads and stores alike.
REQ-025 S2: DIN registered with the lane offset, size and signed flag piped from S0.
REQ-026 S3: LS_LOAD_VLD=1 for legal loads only; LS_LOAD = selected lane(s), zero- or sign-extended to 32 bits; word unchanged.
REQ-027 Fully pipelined: one op accepted every cycle; up to 4 ops in flight; no stall or backpressure.
REQ-028 Latency: pointer writeback 1 cycle after issue, load writeback 3 cycles after issue, aligned with barrel slice rotation.
REQ-029 LS_PTR_SEL == LS_LOAD_SEL on a writeback load: both writebacks are issued; the load (S3) is last and final.
REQ-030 Stores never assert LS_LOAD_VLD; DIN is ignored on store cycles.
REQ-031 When a VLD output is 0, its SEL/data outputs are 0.

Reset
REQ-032 RST_N low: all pipeline valids and registers clear immediately; all registered outputs 0; LS_ERR=0.
REQ-033 Reset mid-operation: in-flight ops discarded; no writeback after reset release for ops issued before it.

Structure
REQ-034 Package tawas_ls_pkg holds size encodings (LS_BYTE/LS_HALF/LS_WORD), DIN latency constant (2) and the S0-S3 stage-count constant.
REQ-035 Sub-module tawas_ls_align: store lane replication and mask generation, plus load lane extraction and extension; combinational, instantiated once per direction.

Verification
REQ-036 Word load, LS_PTR=0x1000, offset 8, DIN=0xDEADBEEF -> DADDR=0x1008, DMASK=F; LS_LOAD=0xDEADBEEF, 3 cycles after issue.
REQ-037 Signed byte load, EA=0x2003, DIN=0x80000000 -> DMASK=8, LS_LOAD=0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Half store with writeback, LS_PTR=0x10, offset 2, LS_STORE=0x1234ABCD -> DWR=1, DMASK=C, DOUT=0xABCDABCD; S1 LS_PTR_UPD=0x12.
REQ-039 Word load, EA=0x1002 -> DCS=0, LS_ERR pulse in S1, no LS_PTR_UPD_VLD, no LS_LOAD_VLD.
REQ-040 Four back-to-back loads, then RST_N low 2 cycles after the last -> no LS_LOAD_VLD after reset; all outputs 0.
